// File: rtl/memory_access_unit_if.sv
// memory_access_unit_if: request/ready data-memory bus between the MEM-stage access unit and data memory
interface memory_access_unit_if;
    logic        DataMem_Read;
    logic [3:0]  DataMem_Write;
    logic [29:0] DataMem_Address;
    logic [31:0] DataMem_Out;
    logic [31:0] DataMem_In;
    logic        DataMem_Ready;

    modport master (
        output DataMem_Read, DataMem_Write, DataMem_Address, DataMem_Out,
        input  DataMem_In, DataMem_Ready
    );

    modport slave (
        input  DataMem_Read, DataMem_Write, DataMem_Address, DataMem_Out,
        output DataMem_In, DataMem_Ready
    );
endinterface

// File: rtl/memory_access_unit.sv
// memory_access_unit: MEM-stage data access with alignment checks, byte-lane/endian steering,
// LL/SC link tracking and a request/ready handshake that stalls the pipeline while outstanding.
module memory_access_unit (
    input  logic        clock,
    input  logic        reset,
    input  logic        M_MemRead,
    input  logic        M_MemWrite,
    input  logic        M_MemByte,
    input  logic        M_MemHalf,
    input  logic        M_MemSignExtend,
    input  logic        M_LLSC,
    input  logic        M_ReverseEndian,
    input  logic [31:0] M_ALU_Result,
    input  logic [31:0] M_ReadData2,
    input  logic        M_Flush,
    input  logic        M_ClearLink,
    input  logic        M_Stall_Ext,
    memory_access_unit_if.master dmem,
    output logic [31:0] M_ReadData,
    output logic        M_Stall_Mem,
    output logic        M_AdEL,
    output logic        M_AdES
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;
    typedef struct packed {
        logic        rd;
        logic        wr;
        logic        llsc;
        logic        sz_b;
        logic        sz_h;
        logic        sext;
        logic [1:0]  o;
        logic [3:0]  we;
        logic [29:0] addr;
        logic [31:0] dout;
    } acc_t;

    state_t      state, state_nx;
    acc_t        live, acc_q, cur;
    logic        link, sz_w, misaligned, sc_fail, valid, req, done_now;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic [31:0] load_v, result, hold_reg;

    always_comb begin
        sz_w       = ~M_MemByte & ~M_MemHalf;
        misaligned = (M_MemHalf & ~M_MemByte & M_ALU_Result[0]) | (sz_w & |M_ALU_Result[1:0]);
        sc_fail    = M_LLSC & M_MemWrite & ~link;
        valid      = (M_MemRead | M_MemWrite) & ~misaligned & ~M_Flush & ~sc_fail;
        live       = '0;
        live.rd    = M_MemRead & valid;
        live.wr    = M_MemWrite & valid;
        live.llsc  = M_LLSC;
        live.sz_b  = M_MemByte;
        live.sz_h  = M_MemHalf & ~M_MemByte;
        live.sext  = M_MemSignExtend;
        live.o     = M_ALU_Result[1:0] ^ (M_MemByte ? {2{M_ReverseEndian}} :
                                          M_MemHalf ? {M_ReverseEndian, 1'b0} : 2'b00);
        live.we    = M_MemByte ? 4'b1000 >> live.o : M_MemHalf ? (live.o[1] ? 4'b0011 : 4'b1100) : 4'b1111;
        live.addr  = M_ALU_Result[31:2];
        live.dout  = M_MemByte ? {4{M_ReadData2[7:0]}} : M_MemHalf ? {2{M_ReadData2[15:0]}} : M_ReadData2;
    end

    // WAIT runs from the snapshot taken at issue, so a late flush or input change cannot disturb it
    assign cur      = (state == S_WAIT) ? acc_q : live;
    assign req      = reset & ((state == S_WAIT) | ((state == S_IDLE) & valid));
    assign done_now = req & dmem.DataMem_Ready;

    always_comb begin
        lane_b = dmem.DataMem_In[{~cur.o, 3'b000} +: 8];
        lane_h = cur.o[1] ? dmem.DataMem_In[15:0] : dmem.DataMem_In[31:16];
        load_v = cur.sz_b ? {{24{cur.sext & lane_b[7]}}, lane_b} :
                 cur.sz_h ? {{16{cur.sext & lane_h[15]}}, lane_h} : dmem.DataMem_In;
        result = cur.rd ? load_v : cur.llsc ? {31'b0, cur.wr} : 32'b0;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            acc_q    <= '0;
            hold_reg <= '0;
            link     <= 1'b0;
        end else begin
            if (state == S_IDLE) acc_q <= live;
            if (done_now) hold_reg <= result;
            if (M_ClearLink) link <= 1'b0;
            else if (done_now & cur.llsc) link <= cur.rd;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (valid) state_nx = !dmem.DataMem_Ready ? S_WAIT : M_Stall_Ext ? S_DONE : S_IDLE;
            S_WAIT:  if (dmem.DataMem_Ready) state_nx = M_Stall_Ext ? S_DONE : S_IDLE;
            S_DONE:  if (!M_Stall_Ext) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // stall drops in the completion cycle so the held instruction advances without re-issuing
    always_comb begin
        dmem.DataMem_Read    = req & cur.rd;
        dmem.DataMem_Write   = (req & cur.wr) ? cur.we : 4'b0000;
        dmem.DataMem_Address = cur.addr;
        dmem.DataMem_Out     = cur.dout;
        M_ReadData           = (state == S_DONE) ? hold_reg : result;
        M_Stall_Mem          = req & ~dmem.DataMem_Ready;
        M_AdEL               = M_MemRead & misaligned;
        M_AdES               = M_MemWrite & misaligned;
    end
endmodule
